// File: rtl/game_flow_controller.sv
// Game sequencer: title, stage load, draw/erase/update frame loop, end screen.
// Owns the frame/step dividers, level progression, pause and loader/renderer handshakes.
module game_flow_controller #(
  parameter int CLK_DIV         = 833333,
  parameter int FRAMES_PER_STEP = 15,
  parameter int NUM_LEVELS      = 3,
  parameter int LVL_W           = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             pause,
  input  logic             load_done,
  input  logic             draw_done,
  input  logic             game_over,
  input  logic             player_won,
  output logic [1:0]       memory_select,
  output logic             load_start,
  output logic             draw_start,
  output logic             erase_start,
  output logic             update_en,
  output logic             reset_stage,
  output logic [LVL_W-1:0] level,
  output logic             frame_tick,
  output logic             paused,
  output logic             end_win
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [3:0] S_IDLE         = 4'd0;
  localparam logic [3:0] S_LOAD_STAGE   = 4'd1;
  localparam logic [3:0] S_STAGE_DRAW   = 4'd2;
  localparam logic [3:0] S_STAGE_IDLE   = 4'd3;
  localparam logic [3:0] S_PAUSED       = 4'd4;
  localparam logic [3:0] S_STAGE_ERASE  = 4'd5;
  localparam logic [3:0] S_STAGE_UPDATE = 4'd6;
  localparam logic [3:0] S_LOAD_END     = 4'd7;
  localparam logic [3:0] S_END_SCREEN   = 4'd8;

  logic [3:0]       state_reg, state_next;
  logic             entry_reg;
  logic             go_prev_reg, pause_prev_reg;
  logic             go_p, pause_p;
  logic [CW-1:0]    ccount_reg;
  logic [FW-1:0]    fcount_reg;
  logic             pending_reg;
  logic [LVL_W-1:0] level_reg;
  logic             end_win_reg;
  logic             count_en, step_tick, last_level, advance_level;

  assign go_p    = go & ~go_prev_reg;
  assign pause_p = pause & ~pause_prev_reg;

  assign count_en = (state_reg == S_STAGE_DRAW) || (state_reg == S_STAGE_IDLE) ||
                    (state_reg == S_STAGE_ERASE) || (state_reg == S_STAGE_UPDATE);
  assign frame_tick = count_en && (ccount_reg == CW'(CLK_DIV - 1));
  assign step_tick  = frame_tick && (fcount_reg == FW'(FRAMES_PER_STEP - 1));

  assign last_level    = (level_reg >= LVL_W'(NUM_LEVELS - 1));
  assign advance_level = game_over && player_won && !last_level;

  // entry_reg marks the first cycle of a state; dones are ignored during it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:         if (go_p) state_next = S_LOAD_STAGE;
      S_LOAD_STAGE:   if (load_done && !entry_reg) state_next = S_STAGE_DRAW;
      S_STAGE_DRAW:   if (draw_done && !entry_reg) state_next = S_STAGE_IDLE;
      S_STAGE_IDLE: begin
        if (pause_p)                        state_next = S_PAUSED;
        else if (step_tick || pending_reg)  state_next = S_STAGE_ERASE;
      end
      S_PAUSED:       if (pause_p) state_next = S_STAGE_IDLE;
      S_STAGE_ERASE:  if (draw_done && !entry_reg) state_next = S_STAGE_UPDATE;
      S_STAGE_UPDATE: begin
        if (advance_level)  state_next = S_LOAD_STAGE;
        else if (game_over) state_next = S_LOAD_END;
        else                state_next = S_STAGE_DRAW;
      end
      S_LOAD_END:     if (load_done && !entry_reg) state_next = S_END_SCREEN;
      S_END_SCREEN:   if (go_p) state_next = S_IDLE;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      entry_reg      <= 1'b0;
      go_prev_reg    <= 1'b0;
      pause_prev_reg <= 1'b0;
      ccount_reg     <= '0;
      fcount_reg     <= '0;
      pending_reg    <= 1'b0;
      level_reg      <= '0;
      end_win_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      entry_reg      <= (state_next != state_reg);
      go_prev_reg    <= go;
      pause_prev_reg <= pause;

      // Dividers run in gameplay, freeze while paused, clear everywhere else.
      if (count_en) begin
        if (frame_tick) begin
          ccount_reg <= '0;
          fcount_reg <= step_tick ? '0 : fcount_reg + 1'b1;
        end else begin
          ccount_reg <= ccount_reg + 1'b1;
        end
      end else if (state_reg != S_PAUSED) begin
        ccount_reg <= '0;
        fcount_reg <= '0;
      end

      // A single pending step covers a renderer overrun; further overruns are dropped.
      if (state_reg == S_STAGE_IDLE && state_next == S_STAGE_ERASE)
        pending_reg <= 1'b0;
      else if (step_tick && state_reg != S_STAGE_IDLE)
        pending_reg <= 1'b1;

      if (state_reg == S_IDLE && go_p)
        level_reg <= '0;
      else if (state_reg == S_STAGE_UPDATE && advance_level)
        level_reg <= level_reg + 1'b1;

      if (state_reg == S_STAGE_UPDATE && game_over && !advance_level)
        end_win_reg <= player_won;
    end
  end

  always_comb begin
    memory_select = 2'd3;
    case (state_reg)
      S_IDLE:                   memory_select = 2'd0;
      S_LOAD_STAGE:             memory_select = 2'd1;
      S_LOAD_END, S_END_SCREEN: memory_select = 2'd2;
      default:                  memory_select = 2'd3;
    endcase
  end

  assign load_start  = entry_reg && (state_reg == S_LOAD_STAGE || state_reg == S_LOAD_END);
  assign draw_start  = entry_reg && (state_reg == S_STAGE_DRAW);
  assign erase_start = entry_reg && (state_reg == S_STAGE_ERASE);
  assign update_en   = (state_reg == S_STAGE_UPDATE);
  assign reset_stage = (state_reg == S_LOAD_STAGE);
  assign paused      = (state_reg == S_PAUSED);
  assign level       = level_reg;
  assign end_win     = end_win_reg;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with small dividers (4 clocks/frame, 3 frames/step, 2 levels).
// Expected values go through a queue and are popped when the DUT output is sampled on the falling edge.
`timescale 1ns/1ps
module tb_game_flow_controller;
  localparam int CLK_DIV = 4;
  localparam int FPS     = 3;
  localparam int NL      = 2;
  localparam int LW      = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic go = 1'b0, pause = 1'b0, load_done = 1'b0, draw_done = 1'b0;
  logic game_over = 1'b0, player_won = 1'b0;
  logic [1:0]    memory_select;
  logic          load_start, draw_start, erase_start, update_en, reset_stage;
  logic [LW-1:0] level;
  logic          frame_tick, paused, end_win;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  game_flow_controller #(
    .CLK_DIV(CLK_DIV), .FRAMES_PER_STEP(FPS), .NUM_LEVELS(NL), .LVL_W(LW)
  ) dut (
    .clock(clock), .reset(reset), .go(go), .pause(pause),
    .load_done(load_done), .draw_done(draw_done),
    .game_over(game_over), .player_won(player_won),
    .memory_select(memory_select), .load_start(load_start),
    .draw_start(draw_start), .erase_start(erase_start),
    .update_en(update_en), .reset_stage(reset_stage), .level(level),
    .frame_tick(frame_tick), .paused(paused), .end_win(end_win)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] v);
    expect_val(tag, v);
    check(obs);
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return erase_start;
      1:       return frame_tick;
      default: return draw_start;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, output int k);
    k = 0;
    while (sig(which) !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
  endtask

  // Called on the erase_start cycle: the first done is ignored, the second starts the update.
  task automatic do_erase(input logic gov, input logic won);
    draw_done = 1'b1;
    tick();
    cmp("erase_done_on_start_ignored", update_en, 0);
    tick();
    cmp("update_en_after_done", update_en, 1);
    draw_done  = 1'b0;
    game_over  = gov;
    player_won = won;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nls, ft_k;

    tick(); tick();
    cmp("rst_memory_select", memory_select, 0);
    cmp("rst_level", level, 0);
    cmp("rst_pulses", {load_start, draw_start, erase_start, update_en}, 0);
    cmp("rst_flags", {reset_stage, paused, end_win, frame_tick}, 0);
    reset = 1'b0;
    tick();

    // go held high: exactly one load.
    go = 1'b1;
    nls = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      nls += int'(load_start);
    end
    cmp("go_held_single_load", nls, 1);
    cmp("load_memory_select", memory_select, 1);
    cmp("load_reset_stage", reset_stage, 1);
    go = 1'b0;

    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    cmp("draw_start_after_load", draw_start, 1);
    cmp("reset_stage_dropped", reset_stage, 0);
    cmp("draw_memory_select", memory_select, 3);

    // Frame tick every 4 cycles from the first counting cycle.
    for (int c = 0; c < 12; c++) expect_val($sformatf("frame_tick_c%0d", c), (c % 4 == 3) ? 1 : 0);
    for (int c = 0; c < 12; c++) begin
      check(frame_tick);
      if (c == 2) draw_done = 1'b1;
      if (c == 3) draw_done = 1'b0;
      tick();
    end
    cmp("erase_on_third_tick", erase_start, 1);
    do_erase(1'b0, 1'b0);
    tick();
    game_over = 1'b0; player_won = 1'b0;
    cmp("redraw_after_update", draw_start, 1);

    // Renderer overruns two steps: one pending step, the second dropped.
    repeat (20) tick();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    cmp("pending_idle_first_cycle", erase_start, 0);
    tick();
    cmp("pending_idle_one_cycle", erase_start, 1);
    do_erase(1'b0, 1'b0);
    tick();
    cmp("draw_after_pending", draw_start, 1);
    tick();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    wait_for(0, 30, k);
    cmp("second_overrun_dropped", k, 6);

    do_erase(1'b0, 1'b0);
    tick();
    cmp("draw_before_pause", draw_start, 1);
    tick();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    pause = 1'b1;
    tick();
    cmp("paused_set", paused, 1);
    cmp("paused_memory_select", memory_select, 3);
    for (int i = 0; i < 6; i++) begin
      cmp("pause_frame_tick_frozen", frame_tick, 0);
      cmp("pause_held_no_resume", paused, 1);
      if (i == 2) pause = 1'b0;
      if (i == 5) pause = 1'b1;
      tick();
    end
    pause = 1'b0;
    cmp("resumed", paused, 0);
    ft_k = -1;
    k = 0;
    while (erase_start !== 1'b1 && k < 30) begin
      if (frame_tick === 1'b1 && ft_k < 0) ft_k = k;
      tick();
      k++;
    end
    cmp("resume_remaining_count", ft_k, 1);
    cmp("resume_step_erase", k, 6);

    // Win level 0 -> reload at level 1.
    do_erase(1'b1, 1'b1);
    tick();
    game_over = 1'b0; player_won = 1'b0;
    cmp("lvl_up_load_start", load_start, 1);
    cmp("lvl_up_level", level, 1);
    cmp("lvl_up_memory_select", memory_select, 1);
    cmp("lvl_up_reset_stage", reset_stage, 1);
    load_done = 1'b1;
    tick();
    cmp("load_done_on_start_ignored", memory_select, 1);
    cmp("load_start_one_cycle", load_start, 0);
    tick();
    load_done = 1'b0;
    cmp("lvl1_draw_start", draw_start, 1);
    tick();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    wait_for(0, 40, k);
    cmp("lvl1_counters_cleared", k, 10);

    // Win last level -> end screen.
    do_erase(1'b1, 1'b1);
    tick();
    game_over = 1'b0; player_won = 1'b0;
    cmp("end_load_start", load_start, 1);
    cmp("end_memory_select", memory_select, 2);
    cmp("end_win_set", end_win, 1);
    cmp("end_level_capped", level, 1);
    cmp("end_reset_stage", reset_stage, 0);
    tick();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    cmp("end_screen_memory_select", memory_select, 2);
    go = 1'b1;
    tick();
    cmp("back_to_idle", memory_select, 0);
    cmp("idle_keeps_level", level, 1);
    tick(); tick();
    cmp("idle_go_held_no_restart", {memory_select, load_start}, 0);
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    cmp("restart_load_start", load_start, 1);
    cmp("restart_level_cleared", level, 0);

    tick();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    cmp("restart_draw_start", draw_start, 1);
    tick();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    wait_for(0, 40, k);
    cmp("restart_erase_start", erase_start, 1);
    tick(); tick(); tick();
    cmp("erase_counters_running", frame_tick, 1);

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1;
    cmp("async_rst_memory_select", memory_select, 0);
    cmp("async_rst_pulses", {load_start, draw_start, erase_start, update_en}, 0);
    cmp("async_rst_flags", {reset_stage, paused, end_win, frame_tick}, 0);
    cmp("async_rst_level", level, 0);
    tick();
    reset = 1'b0;
    tick();
    cmp("post_rst_idle", memory_select, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level game sequencer for the Bomberman datapath: title → stage load → draw/erase/update frame loop → end screen.
- Includes a parametrised frame-tick divider, a step divider, multi-level progression, a pause mode and pulse-based start/done handshakes with the loader and renderer.
- Sits between the board-level inputs (keys, 50 MHz clock) and the memory-select, loader, renderer and stage-logic datapath.

Parameters:
- CLK_DIV, 833333: clock cycles per frame tick (≥2).
- FRAMES_PER_STEP, 15: frame ticks per game step (≥1).
- NUM_LEVELS, 3: number of stages (≥1).
- LVL_W, 2: width of level output; 2^LVL_W ≥ NUM_LEVELS.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  start/continue key, level-sensitive; rising edge used.
- pause  in  1  pause key, level-sensitive; rising edge used.
- load_done  in  1  loader finished pulse.
- draw_done  in  1  renderer finished pulse (draw or erase).
- game_over  in  1  stage logic: round ended.
- player_won  in  1  qualifies game_over; sampled with it.
- memory_select  out  2  0 title, 1 stage background, 2 end screen, 3 live game.
- load_start  out  1  one-cycle pulse starting a background/screen load.
- draw_start  out  1  one-cycle pulse starting a sprite draw.
- erase_start  out  1  one-cycle pulse starting a sprite erase.
- update_en  out  1  one-cycle pulse: stage logic advances one step.
- reset_stage  out  1  high throughout LOAD_STAGE.
- level  out  LVL_W  current stage index.
- frame_tick  out  1  one-cycle pulse every CLK_DIV cycles while counting.
- paused  out  1  high in PAUSED.
- end_win  out  1  registered result of the last round; valid in END states.

Behaviour:
- Reset (async, any time, including mid-load or mid-draw): state IDLE, level 0, all counters 0, pending flag 0, edge-detect regs 0, all pulses 0, reset_stage 0, paused 0, end_win 0. memory_select follows state, so it reads 0.
- Edge detection: go_p = go & ~go_q and pause_p = pause & ~pause_q. Both registers update every cycle.
  - A go held through a transition does not retrigger.
- States and transitions:
  - IDLE → LOAD_STAGE on go_p; level ← 0.
  - LOAD_STAGE → STAGE_DRAW on load_done.
  - STAGE_DRAW → STAGE_IDLE on draw_done.
  - STAGE_IDLE → PAUSED on pause_p. Otherwise → STAGE_ERASE on step_tick or pending. pause_p has priority.
  - PAUSED → STAGE_IDLE on pause_p.
  - STAGE_ERASE → STAGE_UPDATE on draw_done.
  - STAGE_UPDATE, one cycle only:
    - game_over & player_won & level < NUM_LEVELS-1 → level+1, then LOAD_STAGE.
    - game_over otherwise → LOAD_END; end_win ← player_won.
    - No game_over → STAGE_DRAW.
  - LOAD_END → END_SCREEN on load_done.
  - END_SCREEN → IDLE on go_p.
- Start pulses:
  - load_start is high for exactly the first cycle in LOAD_STAGE or LOAD_END.
  - draw_start is high for the first cycle in STAGE_DRAW; erase_start for the first cycle in STAGE_ERASE.
  - A done asserted in the same cycle as its start pulse is ignored; done is accepted from the following cycle.
  - A done seen in any other state is ignored.
- update_en is high for the single STAGE_UPDATE cycle.
- memory_select: IDLE 0; LOAD_STAGE 1; LOAD_END and END_SCREEN 2; all gameplay states and PAUSED 3.
- Dividers:
  - Counting is enabled in STAGE_DRAW, STAGE_IDLE, STAGE_ERASE and STAGE_UPDATE.
  - Counters are held in PAUSED.
  - Counters are cleared to 0 in every other state.
  - Clock counter: 0..CLK_DIV-1, wraps to 0. frame_tick = enabled & (count == CLK_DIV-1).
  - Frame counter: increments on frame_tick, wraps at FRAMES_PER_STEP-1. step_tick = frame_tick & (fcount == FRAMES_PER_STEP-1).
- Pending flag:
  - Set if step_tick occurs outside STAGE_IDLE (the renderer is slower than a step).
  - Cleared when STAGE_IDLE exits to STAGE_ERASE.
  - Saturates: at most one pending step; extras are dropped.
- Level never exceeds NUM_LEVELS-1; it is cleared only on reset or the IDLE→LOAD_STAGE exit.

Test Plan (CLK_DIV=4, FRAMES_PER_STEP=3, NUM_LEVELS=2):
- Reset, go held high 10 cycles → one load_start only; memory_select 0→1; reset_stage high until load_done.
- load_done then draw_done asserted 2 cycles after draw_start:
  - Required: frame_tick every 4 cycles.
  - Required: STAGE_IDLE→STAGE_ERASE on the 3rd frame_tick, i.e. 12 cycles after counting began.
  - Required: erase_start pulse, then update_en one cycle after draw_done.
- Hold draw_done off for 20 cycles in STAGE_DRAW → pending set; STAGE_IDLE lasts exactly 1 cycle; a second overrun step is dropped.
- pause_p in STAGE_IDLE → paused=1 and counters frozen at their values; second pause_p resumes, and the next frame_tick arrives after the remaining count.
- game_over=1, player_won=1 at level 0 → level=1, load_start, memory_select=1. Repeat at level 1 → LOAD_END, end_win=1, memory_select=2. go_p → IDLE, memory_select 0.
- Assert reset mid-STAGE_ERASE with counters nonzero → all outputs at reset values immediately, without waiting for a clock edge.
